// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: payload plus control field behind a valid/ready handshake, with hold, flush and bubble.
// Define PIPE_STAGE_REG_SKID_EN to build a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 24,
    parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              LE,
    input  logic              Flush,
    input  logic              Bubble,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        count
);

    function automatic logic [CTRL_W-1:0] apply_bubble(input logic bubble,
                                                       input logic [CTRL_W-1:0] ctrl);
        return bubble ? NOP_CTRL : ctrl;
    endfunction

    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;
    logic [CTRL_W-1:0] ctrl_p0;
    logic              vld_p0_nxt;
    logic              load_main_in;
    logic              it;
    logic              ot;
    logic [CTRL_W-1:0] ctrl_in;

    assign ctrl_in   = apply_bubble(Bubble, in_ctrl);
    assign out_valid = vld_p0 & LE & Reset;
    assign it        = in_valid & in_ready & LE & Reset & !Flush;
    assign ot        = out_valid & out_ready;
    assign out_data  = data_p0;
    assign out_ctrl  = ctrl_p0;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic              rdy_q;
    logic              vld_p1_nxt;
    logic              load_main_skid;
    logic              load_skid;

    // rdy_q only ever depends on state, so out_ready has no path to in_ready
    assign in_ready = rdy_q & LE & Reset;
    assign count    = {1'b0, vld_p0} + {1'b0, vld_p1};

    always_comb begin
        vld_p0_nxt     = vld_p0;
        vld_p1_nxt     = vld_p1;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (it && (!vld_p0 || ot)) begin
            load_main_in = 1'b1;
            vld_p0_nxt   = 1'b1;
        end else if (it) begin
            load_skid  = 1'b1;
            vld_p1_nxt = 1'b1;
        end else if (ot) begin
            if (vld_p1) begin
                load_main_skid = 1'b1;
                vld_p1_nxt     = 1'b0;
            end else begin
                vld_p0_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            rdy_q   <= 1'b1;
            data_p0 <= '0;
            ctrl_p0 <= NOP_CTRL;
        end else if (Flush) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            rdy_q  <= 1'b1;
        end else if (LE) begin
            vld_p0 <= vld_p0_nxt;
            vld_p1 <= vld_p1_nxt;
            rdy_q  <= !vld_p1_nxt;
            if (load_main_in) begin
                data_p0 <= in_data;
                ctrl_p0 <= ctrl_in;
            end else if (load_main_skid) begin
                data_p0 <= data_p1;
                ctrl_p0 <= ctrl_p1;
            end
        end
    end

    // skid payload is only meaningful while vld_p1 is set
    always_ff @(posedge clk) begin
        if (load_skid) begin
            data_p1 <= in_data;
            ctrl_p1 <= ctrl_in;
        end
    end
`else
    assign in_ready = LE & Reset & (!vld_p0 | out_ready);
    assign count    = {1'b0, vld_p0};

    always_comb begin
        vld_p0_nxt   = vld_p0;
        load_main_in = it;
        if (it) begin
            vld_p0_nxt = 1'b1;
        end else if (ot) begin
            vld_p0_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            ctrl_p0 <= NOP_CTRL;
        end else if (Flush) begin
            vld_p0 <= 1'b0;
        end else if (LE) begin
            vld_p0 <= vld_p0_nxt;
            if (load_main_in) begin
                data_p0 <= in_data;
                ctrl_p0 <= ctrl_in;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; expectations follow PIPE_STAGE_REG_SKID_EN when it is defined.
module tb_pipe_stage_reg;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 24;
    localparam logic [CTRL_W-1:0] NOP = 24'h00C3A5;

    logic              clk = 1'b0;
    logic              Reset, LE, Flush, Bubble;
    logic              in_valid, in_ready, out_valid, out_ready;
    logic [DATA_W-1:0] in_data, out_data;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [1:0]        count;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_CTRL(NOP)) dut (
        .clk(clk), .Reset(Reset), .LE(LE), .Flush(Flush), .Bubble(Bubble),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0; LE = 1'b1; Flush = 1'b0; Bubble = 1'b0;
        in_valid = 1'b1; in_data = 64'hA5; in_ctrl = 24'h123456; out_ready = 1'b0;

        // reset held for two edges with an offered entry
        step(); step();
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_ctrl", out_ctrl, NOP);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);

        Reset = 1'b1; in_valid = 1'b0;
        #1;
        check("rel_in_ready_now", in_ready, 1);
        step();
        check("rel_in_ready", in_ready, 1);
        check("rel_out_valid", out_valid, 0);
        check("rel_count", count, 0);

        // streaming
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 64'(i); in_ctrl = 24'(i * 24'h000101);
            step();
            check("stream_valid", out_valid, 1);
            check("stream_data", out_data, 64'(i));
            check("stream_ctrl", out_ctrl, 24'(i * 24'h000101));
            check("stream_count", count, 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain_valid", out_valid, 0);
        check("stream_drain_count", count, 0);

        // backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h10; in_ctrl = 24'h000010;
        step();
        check("bp_count1", count, 1);
        check("bp_data10", out_data, 64'h10);
`ifdef PIPE_STAGE_REG_SKID_EN
        in_data = 64'h11; in_ctrl = 24'h000011;
        step();
        check("bp_count2", count, 2);
        check("bp_in_ready0", in_ready, 0);
        check("bp_data10_b", out_data, 64'h10);
        in_data = 64'h12; in_ctrl = 24'h000012;
        step();
        check("bp_hold_count", count, 2);
        check("bp_hold_data", out_data, 64'h10);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_regd", in_ready, 0);
        step();
        check("bp_data11", out_data, 64'h11);
        check("bp_ctrl11", out_ctrl, 24'h000011);
        check("bp_count_after1", count, 1);
        check("bp_in_ready1", in_ready, 1);
        step();
        check("bp_data12", out_data, 64'h12);
        check("bp_count_after2", count, 1);
        in_valid = 1'b0;
        step();
        check("bp_empty", out_valid, 0);
        check("bp_empty_count", count, 0);
`else
        check("bp_in_ready0", in_ready, 0);
        in_data = 64'h11; in_ctrl = 24'h000011;
        step();
        check("bp_hold_data", out_data, 64'h10);
        check("bp_hold_count", count, 1);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_comb", in_ready, 1);
        step();
        check("bp_replace_data", out_data, 64'h11);
        check("bp_replace_count", count, 1);
        in_valid = 1'b0;
        step();
        check("bp_empty", out_valid, 0);
        check("bp_empty_count", count, 0);
`endif

        // bubble replaces control only
        out_ready = 1'b1; in_valid = 1'b1; Bubble = 1'b1;
        in_ctrl = 24'hFFFFFF; in_data = 64'h55;
        step();
        check("bub_ctrl", out_ctrl, NOP);
        check("bub_data", out_data, 64'h55);
        Bubble = 1'b0; in_ctrl = 24'hABCDEF; in_data = 64'h66;
        step();
        check("nobub_ctrl", out_ctrl, 24'hABCDEF);
        check("nobub_data", out_data, 64'h66);
        in_valid = 1'b0;
        step();

        // flush with an entry offered
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h20; in_ctrl = 24'h000020;
        step();
`ifdef PIPE_STAGE_REG_SKID_EN
        in_data = 64'h21; in_ctrl = 24'h000021;
        step();
        check("fl_pre_count", count, 2);
`else
        check("fl_pre_count", count, 1);
`endif
        Flush = 1'b1; out_ready = 1'b1; in_data = 64'h99; in_ctrl = 24'h000099;
        step();
        check("fl_count", count, 0);
        check("fl_out_valid", out_valid, 0);
        check("fl_data_kept", out_data, 64'h20);
        Flush = 1'b0; in_valid = 1'b0;
        step();
        check("fl_dropped_valid", out_valid, 0);
        check("fl_dropped_count", count, 0);

        // hold with LE=0
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h77; in_ctrl = 24'h000777;
        step();
        LE = 1'b0; out_ready = 1'b1; in_data = 64'h88; in_ctrl = 24'h000888;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_out_valid", out_valid, 0);
            check("hold_in_ready", in_ready, 0);
            step();
            check("hold_count", count, 1);
        end
        in_valid = 1'b0; LE = 1'b1;
        #1;
        check("hold_resume_valid", out_valid, 1);
        check("hold_resume_data", out_data, 64'h77);
        check("hold_resume_ctrl", out_ctrl, 24'h000777);
        step();
        check("hold_drain_count", count, 0);

        // flush wins over LE=0
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h30;
        step();
        in_valid = 1'b0; LE = 1'b0; Flush = 1'b1;
        step();
        Flush = 1'b0; LE = 1'b1;
        #1;
        check("fl_le0_count", count, 0);
        check("fl_le0_valid", out_valid, 0);

        // reset mid-stream
        in_valid = 1'b1; in_data = 64'h40; in_ctrl = 24'h000040;
        step();
        in_valid = 1'b0; Reset = 1'b0; out_ready = 1'b1;
        #1;
        check("mid_rst_no_ot", out_valid, 0);
        step();
        check("mid_rst_count", count, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_ctrl", out_ctrl, NOP);
        Reset = 1'b1;
        step();
        check("mid_rst_rel_count", count, 0);
        check("mid_rst_rel_ready", in_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the PA-RISC pipeline: the successor to the fixed-field IF_ID / ID_EX / EX_MEM / MEM_WB latches. It carries an arbitrary data payload plus a control-signal field between stages through a valid/ready handshake. It supports:
- global hold (LE),
- flush (squash),
- bubble insertion (control field forced to NOP, as the control-unit mux does today),
- an optional two-entry skid buffer that registers `in_ready` for timing closure.

## Interface
Parameters:
- DATA_W, 64: payload width (PC, operands, immediates, RD, etc.).
- CTRL_W, 24: control field width (BL, SOH_OP, ALU_OP, RAM_CTRL, L, SR, RF_LE, PSW_EN, CO_EN, COMB, ...).
- NOP_CTRL, {CTRL_W{1'b0}}: control value substituted on bubble and loaded at reset.

Ports:
- clk  in  1  rising-edge clock; one clock for the whole block.
- Reset  in  1  synchronous, active-low reset.
- LE  in  1  stage enable. 0 freezes all state and blocks both handshakes.
- Flush  in  1  squashes every held entry at the next edge.
- Bubble  in  1  when an input transfer occurs, its control field is replaced by NOP_CTRL.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage can accept an entry.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control field.
- out_valid  out  1  stage presents an entry.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  presented payload.
- out_ctrl  out  CTRL_W  presented control field.
- count  out  2  entries held (0..1 without skid, 0..2 with skid).

## Operation
- Input transfer (IT): in_valid & in_ready & LE & Reset & !Flush.
- Output transfer (OT): out_valid & out_ready. out_valid is already masked by LE.
- Bubble applies only to the entry accepted in an IT. Data is never altered by Bubble.
- Priority at each edge: Reset=0 > Flush=1 > LE=0 > normal transfers.

Reset (Reset=0 at edge):
- count=0, out_valid=0, out_data=0, out_ctrl=NOP_CTRL.
- While Reset=0, in_ready=0.

Flush:
- count becomes 0 and out_valid 0 next cycle. out_data/out_ctrl keep their values.
- An IT offered in the flush cycle is dropped, even though in_ready may read 1.

LE=0:
- out_valid and in_ready are forced to 0 combinationally.
- Internal state is held; no transfer occurs.

Without skid (single entry):
- in_ready = LE & Reset & (!held | out_ready).
- On IT, the entry is loaded into the output register.
- On OT without IT, the stage empties.
- IT and OT in the same cycle: replace the entry; count stays 1.

With skid (two entries: main feeds the outputs, skid is overflow):
- in_ready is a flop: 1 when count ≤ 1 after the edge.
- IT while main is empty, or while main is being drained by OT with skid empty → main.
- IT while main is full and not draining → skid.
- OT with skid full: skid moves to main.
- IT and OT in the same cycle with count=2 is impossible, because in_ready=0.
- Entries always leave in arrival order.

## Timing
- Latency: 1 cycle from IT to out_valid=1 with that entry, in both modes.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- in_ready:
  - Without skid: combinational from out_ready.
  - With skid: registered, no combinational path from out_ready.
- First cycle after reset release: in_ready=1 (if LE=1), out_valid=0, count=0.
- Flush while LE=0: flush still takes effect (priority above LE).
- Reset asserted mid-stream: every held entry is lost; no OT is reported while Reset=0.

## Configuration
- Macro PIPE_STAGE_REG_SKID_EN.
- Defined: two-entry skid buffer, registered in_ready, count range 0..2.
- Undefined: single entry, combinational in_ready, count range 0..1. The skid flops are not built.

## Test plan
- Reset: hold Reset=0 for 2 cycles with in_valid=1, in_data=0xA5 → count=0, out_valid=0, out_ctrl=NOP_CTRL, in_ready=0. After release: in_ready=1 next cycle.
- Streaming: out_ready=1, feed data 1,2,3 on consecutive cycles → out_data 1,2,3 on the following consecutive cycles, count=1 steady.
- Backpressure (skid build): feed 0x10, 0x11, 0x12 with out_ready=0 → count=2 and in_ready=0 after 0x11; 0x12 is held upstream. Raise out_ready → output order 0x10, 0x11, 0x12.
- Bubble: IT with in_ctrl=0xFFFFFF, Bubble=1, in_data=0x55 → out_ctrl=NOP_CTRL, out_data=0x55.
- Flush: count=2, assert Flush with in_valid=1 → next cycle count=0 and out_valid=0; the offered entry never appears at the output.
- Hold: LE=0 for 3 cycles with count=1 and out_ready=1 → out_valid=0 and in_ready=0 throughout. With LE=1 again, the held entry appears unchanged.
